// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end constants and types
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {pc, instr} with synchronous flush
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    input  logic            pop,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr,
    output logic [CW-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    // A pop frees the slot being written, so push at full is legal alongside a pop.
    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != FULL) || do_pop);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with credit-limited requests and prefetch queue
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_after;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            keep;
    logic            out_fire;
    logic            q_empty;
    fetch_state_e    state;

    assign target         = redirect_target & ~XLEN'(3);
    assign credit_used    = {1'b0, q_count} + {1'b0, inflight};
    // Gated by rst so no request is presented while held in reset.
    assign imem_req_valid = rst && !redirect_valid && (credit_used < CAP);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_empty        = (q_count == '0);
    assign out_valid      = !q_empty && !redirect_valid;
    assign out_fire       = out_valid && out_ready;
    assign out_instr      = q_empty ? XLEN'(NOP) : head_instr;
    assign out_pc         = q_empty ? '0 : head_pc;
    assign out_pc_plus4   = q_empty ? '0 : head_pc + XLEN'(4);

    // A response landing in a redirect cycle belongs to the old stream.
    assign keep           = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign inflight_after = inflight - CW'(imem_rsp_valid);

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (keep),
        .push_pc    (rsp_pc),
        .push_instr (imem_rsp_data),
        .pop        (out_fire),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (q_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            state    <= RUN;
        end else begin
            inflight <= inflight_after + CW'(req_fire);
            if (redirect_valid) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                drop_cnt <= inflight_after;
                state    <= (inflight_after != '0) ? DRAIN : RUN;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (keep)     rsp_pc   <= rsp_pc + XLEN'(4);
                if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
                if ((state == DRAIN) &&
                    ((drop_cnt == '0) || (imem_rsp_valid && (drop_cnt == CW'(1)))))
                    state <= RUN;
            end
        end
    end

endmodule
